led_uart_reporter: RTL and testbench

Downstream consumer of the CPU core's 8-bit LED output byte.
- Watches the byte and, whenever it changes, sends it over a UART TX pin as an ASCII line: two uppercase hex digits, then CR, then LF.
- Gives a serial trace of program progress on the board, alongside the LEDs.
- Sits between the core's LED output and the board's UART TX pin.

---
 rtl/led_uart_pkg.sv | 40 ++++
 rtl/uart_tx_byte.sv | 159 +++++++++++++++
 rtl/led_uart_reporter.sv | 84 ++++++++
 tb/tb_led_uart_reporter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_uart_pkg.sv
// -----------------------------------------------------------------------------
// led_uart_pkg
// Shared definitions for the LED-to-UART reporter:
//   - tx_state_e   : serializer state encoding (IDLE/START/DATA/PARITY/STOP)
//   - ASCII_*      : character constants used to build a report line
//   - nibble_to_hex: 4-bit value -> uppercase ASCII hex digit
//   - msg_char     : character idx (0..3) of the report line for a byte
// -----------------------------------------------------------------------------
package led_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A_OFS = 8'h37;

   function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
      return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A_OFS + {4'h0, n});
   endfunction

   // Line layout: hi digit, lo digit, CR, LF.
   function automatic logic [7:0] msg_char(input logic [7:0] v, input logic [1:0] idx);
      logic [7:0] c;
      case (idx)
         2'd0:    c = nibble_to_hex(v[7:4]);
         2'd1:    c = nibble_to_hex(v[3:0]);
         2'd2:    c = ASCII_CR;
         default: c = ASCII_LF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Byte serializer: start bit, 8 data bits LSB first, optional even parity,
// stop bit. Every bit lasts CLKS_PER_BIT cycles.
// Optional feature macro: LED_UART_PARITY_EN (adds an even-parity bit).
// Ports:
//   in_clock  : system clock (rising edge)
//   in_reset  : synchronous reset, active low
//   in_valid  : byte offered on in_data
//   in_data   : byte to send
//   out_ready : byte is accepted this cycle if in_valid (IDLE, or last cycle
//               of STOP so frames chain with no gap)
//   out_tx    : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
   import led_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int BAUD_CNT_W   = 16
) (
   input  logic       in_clock,
   input  logic       in_reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       out_ready,
   output logic       out_tx
);

   localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_CNT_W-1:0] BAUD_ONE  = BAUD_CNT_W'(1);

   tx_state_e             state_q, state_d;
   logic [BAUD_CNT_W-1:0] baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shreg_q, shreg_d;
   logic                  tx_q, tx_d;
   logic                  last_cyc;
   logic                  accept;
`ifdef LED_UART_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign last_cyc = (baud_q == BAUD_LAST);
   assign out_tx   = tx_q;

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
`ifdef LED_UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
`ifdef LED_UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;
`ifdef LED_UART_PARITY_EN
      par_d     = par_q;
`endif
      out_ready = 1'b0;
      accept    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            out_ready = 1'b1;
            tx_d      = 1'b1;
            accept    = in_valid;
         end
         ST_START: begin
            if (last_cyc) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shreg_q[0];
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (last_cyc) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef LED_UART_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shreg_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
`ifdef LED_UART_PARITY_EN
         ST_PARITY: begin
            if (last_cyc) begin
               baud_d  = '0;
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
`endif
         ST_STOP: begin
            if (last_cyc) begin
               baud_d    = '0;
               out_ready = 1'b1;
               // Next byte takes over on this same edge; otherwise go idle.
               if (in_valid) begin
                  accept = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase

      if (accept) begin
         state_d = ST_START;
         baud_d  = '0;
         tx_d    = 1'b0;
         shreg_d = in_data;
`ifdef LED_UART_PARITY_EN
         par_d   = ^in_data;
`endif
      end
   end

endmodule

// File: rtl/led_uart_reporter.sv
// -----------------------------------------------------------------------------
// led_uart_reporter
// Watches the core's LED byte and, whenever it differs from the last reported
// value (or on the first opportunity after reset), sends it over UART as
// two uppercase hex digits followed by CR LF. Changes seen while a line is in
// flight are not queued: only the value present at the first idle cycle is
// compared against the last one sent.
// Optional feature macro: LED_UART_PARITY_EN (even parity on every character).
// Ports:
//   in_clock : system clock (rising edge)
//   in_reset : synchronous reset, active low
//   in_value : LED byte to report
//   out_tx   : registered UART TX line, idle high
//   out_busy : registered, high while a line is in flight
// -----------------------------------------------------------------------------
module led_uart_reporter
   import led_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int BAUD_CNT_W   = 16
) (
   input  logic       in_clock,
   input  logic       in_reset,
   input  logic [7:0] in_value,
   output logic       out_tx,
   output logic       out_busy
);

   logic       busy_q;
   logic [1:0] char_q;        // character currently on the wire
   logic [7:0] snap_q;        // frozen copy of the value being reported
   logic [7:0] last_q;
   logic       force_q;

   logic       trigger, step, done;
   logic       tx_valid, tx_ready;
   logic [7:0] tx_data;

   assign out_busy = busy_q;

   always_comb begin
      trigger  = !busy_q && ((in_value != last_q) || force_q);
      // While busy the serializer is never idle, so ready marks the end of STOP.
      step     = busy_q && tx_ready && (char_q != 2'd3);
      done     = busy_q && tx_ready && (char_q == 2'd3);
      tx_valid = trigger || step;
      // Char 0 comes straight from in_value since snap loads on the same edge.
      tx_data  = trigger ? nibble_to_hex(in_value[7:4]) : msg_char(snap_q, char_q + 2'd1);
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         busy_q  <= 1'b0;
         char_q  <= '0;
         snap_q  <= '0;
         last_q  <= '0;
         force_q <= 1'b1;
      end else if (trigger) begin
         busy_q  <= 1'b1;
         char_q  <= '0;
         snap_q  <= in_value;
         last_q  <= in_value;
         force_q <= 1'b0;
      end else if (step) begin
         char_q <= char_q + 2'd1;
      end else if (done) begin
         busy_q <= 1'b0;
         char_q <= '0;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .BAUD_CNT_W   (BAUD_CNT_W)
   ) u_tx (
      .in_clock  (in_clock),
      .in_reset  (in_reset),
      .in_valid  (tx_valid),
      .in_data   (tx_data),
      .out_ready (tx_ready),
      .out_tx    (out_tx)
   );

endmodule

// File: tb/tb_led_uart_reporter.sv
// -----------------------------------------------------------------------------
// tb_led_uart_reporter
// Drives LED values, decodes the UART line and compares against a reference
// of what should be reported (last-reported tracking, hex text lookup, even
// parity by bit count). Build with +define+LED_UART_PARITY_EN for 11-bit frames.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_uart_reporter;

   localparam int CPB = 4;
`ifdef LED_UART_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   localparam int MSG_LEN = 4 * FRAME * CPB;

   logic       in_clock = 1'b0;
   logic       in_reset = 1'b0;
   logic [7:0] in_value = 8'h00;
   logic       out_tx;
   logic       out_busy;

   int checks = 0;
   int errors = 0;
   int busy_lens[$];
   logic [7:0] mlast;

   led_uart_reporter #(.CLKS_PER_BIT(CPB), .BAUD_CNT_W(16)) dut (
      .in_clock (in_clock),
      .in_reset (in_reset),
      .in_value (in_value),
      .out_tx   (out_tx),
      .out_busy (out_busy)
   );

   always #5 in_clock = ~in_clock;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Length of every completed busy window; windows cut by reset are dropped.
   initial begin
      int bcnt = 0;
      forever begin
         @(negedge in_clock);
         if (!in_reset) bcnt = 0;
         else if (out_busy === 1'b1) bcnt++;
         else if (bcnt != 0) begin
            busy_lens.push_back(bcnt);
            bcnt = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic rx_bit(input bit have_first, output logic v, output bit ok);
      if (!have_first) @(negedge in_clock);
      v  = out_tx;
      ok = 1'b1;
      for (int i = 1; i < CPB; i++) begin
         @(negedge in_clock);
         if (out_tx !== v) ok = 1'b0;
      end
   endtask

   // Waits for the start bit (latency in negedges from now), then decodes a line.
   task automatic recv_msg(input logic [7:0] v, input int exp_lat);
      string      hexd = "0123456789ABCDEF";
      int         n = 0;
      logic       b;
      bit         ok, okall;
      logic [7:0] byt, exp_c;
      do begin
         @(negedge in_clock);
         n++;
      end while (out_tx !== 1'b0 && n < 200);
      chk("start_latency", n, exp_lat);
      if (out_tx !== 1'b0) return;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0:       exp_c = hexd[v[7:4]];
            1:       exp_c = hexd[v[3:0]];
            2:       exp_c = 8'h0D;
            default: exp_c = 8'h0A;
         endcase
         okall = 1'b1;
         rx_bit(c == 0, b, ok); okall &= ok;
         chk("start_bit", int'(b), 0);
         for (int i = 0; i < 8; i++) begin
            rx_bit(1'b0, b, ok); okall &= ok;
            byt[i] = b;
         end
         chk("char", int'(byt), int'(exp_c));
`ifdef LED_UART_PARITY_EN
         rx_bit(1'b0, b, ok); okall &= ok;
         chk("parity", int'(b), $countones(exp_c) % 2);
`endif
         rx_bit(1'b0, b, ok); okall &= ok;
         chk("stop_bit", int'(b), 1);
         chk("bit_width", int'(okall), 1);
      end
   endtask

   task automatic busy_check(input int n_exp);
      repeat (2) @(negedge in_clock);
      chk("busy_count", busy_lens.size(), n_exp);
      while (busy_lens.size() > 0) chk("busy_len", busy_lens.pop_front(), MSG_LEN);
   endtask

   task automatic no_msg(input int cycles);
      int bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge in_clock);
         if (out_tx !== 1'b1 || out_busy !== 1'b0) bad++;
      end
      chk("quiet", bad, 0);
   endtask

   task automatic set_after(input int cyc, input logic [7:0] v);
      repeat (cyc) @(negedge in_clock);
      in_value = v;
   endtask

   initial begin
      int         n;
      logic [7:0] v, w;

      // reset state
      repeat (3) @(negedge in_clock);
      chk("rst_tx", int'(out_tx), 1);
      chk("rst_busy", int'(out_busy), 0);

      // first value after reset is always reported, even 00
      in_reset = 1'b1;
      recv_msg(8'h00, 1);
      busy_check(1);
      mlast = 8'h00;

      // plain change while idle
      in_value = 8'h3A;
      recv_msg(8'h3A, 1);
      busy_check(1);

      // changes in flight: only the value held at the first idle cycle counts
      in_value = 8'hC7;
      fork
         recv_msg(8'hC7, 1);
         begin
            set_after(20, 8'h12);
            set_after(20, 8'h34);
            set_after(20, 8'h56);
         end
      join
      recv_msg(8'h56, 2);
      busy_check(2);
      no_msg(60);

      // change away and back to last_sent while busy: nothing further
      in_value = 8'h3A;
      fork
         recv_msg(8'h3A, 1);
         begin
            set_after(30, 8'hFF);
            set_after(30, 8'h3A);
         end
      join
      busy_check(1);
      no_msg(1000);

      // reset in the middle of data bit 3 of char 1
      in_value = 8'h5B;
      n = 0;
      do begin
         @(negedge in_clock);
         n++;
      end while (out_tx !== 1'b0 && n < 50);
      chk("abort_start", n, 1);
      repeat (57) @(negedge in_clock);
      in_reset = 1'b0;
      @(negedge in_clock);
      chk("abort_tx", int'(out_tx), 1);
      chk("abort_busy", int'(out_busy), 0);
      repeat (2) @(negedge in_clock);
      in_reset = 1'b1;
      recv_msg(8'h5B, 1);
      busy_check(1);

      // parity-rich value
      in_value = 8'hD3;
      recv_msg(8'hD3, 1);
      busy_check(1);
      mlast = 8'hD3;

      // randomized: repeats, fresh values, and in-flight changes
      for (int it = 0; it < 14; it++) begin
         repeat (3) @(negedge in_clock);
         if ($urandom_range(0, 3) == 0) v = mlast;
         else v = 8'($urandom_range(0, 255));
         in_value = v;
         if (v == mlast) begin
            no_msg(50);
         end else begin
            w = v;
            fork
               recv_msg(v, 1);
               if ($urandom_range(0, 1) == 1) begin
                  w = 8'($urandom_range(0, 255));
                  set_after($urandom_range(10, 90), w);
               end
            join
            if (w != v) begin
               recv_msg(w, 2);
               busy_check(2);
            end else begin
               busy_check(1);
            end
            mlast = w;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
